// File: rtl/led_mode_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_mode_sequencer_if : key event inputs and LED/mode/speed outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface led_mode_sequencer_if;
  logic       key_flag0;
  logic       key_state0;
  logic       key_flag1;
  logic       key_state1;
  logic [1:0] led;
  logic [1:0] mode;
  logic [1:0] speed;

  modport master (
    output key_flag0, key_state0, key_flag1, key_state1,
    input  led, mode, speed
  );

  modport slave (
    input  key_flag0, key_state0, key_flag1, key_state1,
    output led, mode, speed
  );
endinterface

`default_nettype wire

// File: rtl/led_mode_sequencer.sv
// ---------------------------------------------------------------------------
// led_mode_sequencer : key presses select mode/speed of a 2-bit LED pattern
// (off, blink, alternate, PWM breathe). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_mode_sequencer #(
  parameter int TICK_BASE      = 12500000,
  parameter int STEP_TICKS     = 48828,
  parameter int PWM_BITS       = 8,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  wire logic          Clk,
  input  wire logic          Rst,
  led_mode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_ALT     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int TW = $clog2(TICK_BASE);
  localparam int SW = $clog2(STEP_TICKS);
  localparam logic [TW:0]         TICK_PERIOD0 = (TW+1)'(TICK_BASE);
  localparam logic [SW:0]         STEP_PERIOD0 = (SW+1)'(STEP_TICKS);
  localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE     = PWM_BITS'(1);
  localparam logic [1:0]          LED_OFF      = LED_ACTIVE_LOW ? 2'b11 : 2'b00;

  mode_e               mode_q, mode_d;
  logic [1:0]          speed_q, speed_d;
  logic [TW-1:0]       tick_cnt;
  logic [SW-1:0]       step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                dir_down;
  logic                phase;
  logic [1:0]          led_q;

  logic                press0, press1, restart, breathe;
  logic [TW:0]         tick_period;
  logic [SW:0]         step_period;
  logic                tick, step, raw;
  logic [1:0]          pat;

  assign press0  = bus.key_flag0 & ~bus.key_state0;
  assign press1  = bus.key_flag1 & ~bus.key_state1;
  assign restart = press0 | press1;
  assign breathe = (mode_q == MODE_BREATHE);

  // Periods are >= 8 at speed 0, so a shift of at most 3 never reaches 0.
  assign tick_period = TICK_PERIOD0 >> speed_q;
  assign step_period = STEP_PERIOD0 >> speed_q;
  assign tick        = ({1'b0, tick_cnt} == (tick_period - 1'b1));
  assign step        = ({1'b0, step_cnt} == (step_period - 1'b1));
  assign raw         = (pwm_cnt < duty);

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (press0) mode_d  = mode_e'(mode_q + 2'd1);
    if (press1) speed_d = speed_q + 2'd1;
  end

  always_comb begin
    pat = 2'b00;
    case (mode_q)
      MODE_OFF:     pat = 2'b00;
      MODE_BLINK:   pat = {phase, phase};
      MODE_ALT:     pat = {phase, ~phase};
      MODE_BREATHE: pat = {raw, raw};
      default:      pat = 2'b00;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode_q   <= MODE_OFF;
      speed_q  <= 2'd0;
      tick_cnt <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
      phase    <= 1'b0;
      led_q    <= LED_OFF;
    end else begin
      mode_q  <= mode_d;
      speed_q <= speed_d;
      led_q   <= LED_ACTIVE_LOW ? ~pat : pat;
      if (restart) begin
        tick_cnt <= '0;
        step_cnt <= '0;
        pwm_cnt  <= '0;
        duty     <= '0;
        dir_down <= 1'b0;
        phase    <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) phase <= ~phase;
        if (breathe) begin
          step_cnt <= step ? '0 : step_cnt + 1'b1;
          pwm_cnt  <= pwm_cnt + 1'b1;
          // Triangle ramp: direction flips on the step that lands on an end.
          if (step) begin
            if (!dir_down) begin
              duty <= duty + 1'b1;
              if (duty == DUTY_MAX - 1'b1) dir_down <= 1'b1;
            end else begin
              duty <= duty - 1'b1;
              if (duty == DUTY_ONE) dir_down <= 1'b0;
            end
          end
        end else begin
          step_cnt <= '0;
          pwm_cnt  <= '0;
          duty     <= '0;
          dir_down <= 1'b0;
        end
      end
    end
  end

  assign bus.led   = led_q;
  assign bus.mode  = mode_q;
  assign bus.speed = speed_q;

endmodule

`default_nettype wire
